// File: rtl/serial_alu.sv
// Bit-serial ALU: processes SLICE bits per cycle over XLEN/SLICE cycles, LSB group first.
// Define SERIAL_ALU_CMP_EN to build SLT/SLTU; otherwise Op 5/6 behave like the reserved Op 7.
module serial_alu #(
    parameter int XLEN  = 32,
    parameter int SLICE = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] InA,
    input  logic [XLEN-1:0] InB,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] OutC,
    output logic            CarryOut,
    output logic            Zero
);

    localparam int N  = XLEN / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_SLTU = 3'd6;
    localparam logic [2:0] OP_RSV  = 3'd7;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] outc_q, outc_d;
    logic            cout_q, cout_d;

`ifdef SERIAL_ALU_CMP_EN
    logic            aMsb_q, aMsb_d;
    logic            bMsb_q, bMsb_d;
    logic            ltSigned;
`endif

    logic [SLICE-1:0]      aSl, bSl, bEff, sliceRes;
    logic [SLICE:0]        sum;
    logic [XLEN+SLICE-1:0] accShift;
    logic [XLEN-1:0]       accNext;
    logic                  subPath;
    logic                  lastSlice;

    // Comparisons reuse the subtract path, so they also need the inverted-B / carry-in-1 setup.
    function automatic logic usesSub(input logic [2:0] op);
`ifdef SERIAL_ALU_CMP_EN
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
`else
        return (op == OP_SUB);
`endif
    endfunction

    assign aSl       = a_q[SLICE-1:0];
    assign bSl       = b_q[SLICE-1:0];
    assign subPath   = usesSub(op_q);
    assign bEff      = subPath ? ~bSl : bSl;
    assign sum       = {1'b0, aSl} + {1'b0, bEff} + {{SLICE{1'b0}}, carry_q};
    assign accShift  = {sliceRes, acc_q};
    assign accNext   = accShift[XLEN+SLICE-1:SLICE];
    assign lastSlice = (cnt_q == CW'(N - 1));

`ifdef SERIAL_ALU_CMP_EN
    // Differing signs decide directly; equal signs cannot overflow, so the difference sign is exact.
    assign ltSigned = (aMsb_q ^ bMsb_q) ? aMsb_q : sum[SLICE-1];
`endif

    always_comb begin
        sliceRes = '0;
        case (op_q)
            OP_ADD, OP_SUB: sliceRes = sum[SLICE-1:0];
            OP_OR:          sliceRes = aSl | bSl;
            OP_XOR:         sliceRes = aSl ^ bSl;
            OP_AND:         sliceRes = ~(~aSl | ~bSl);
            default:        sliceRes = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        outc_d  = outc_q;
        cout_d  = cout_q;
`ifdef SERIAL_ALU_CMP_EN
        aMsb_d  = aMsb_q;
        bMsb_d  = bMsb_q;
`endif
        case (state_q)
            RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                acc_d   = accNext;
                carry_d = sum[SLICE];
                cnt_d   = cnt_q + CW'(1);
                if (lastSlice) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            outc_d = accNext;
                            cout_d = sum[SLICE];
                        end
                        OP_OR, OP_XOR, OP_AND: begin
                            outc_d = accNext;
                            cout_d = 1'b0;
                        end
`ifdef SERIAL_ALU_CMP_EN
                        OP_SLT: begin
                            outc_d = {{(XLEN-1){1'b0}}, ltSigned};
                            cout_d = 1'b0;
                        end
                        OP_SLTU: begin
                            outc_d = {{(XLEN-1){1'b0}}, ~sum[SLICE]};
                            cout_d = 1'b0;
                        end
`else
                        OP_SLT, OP_SLTU, OP_RSV: begin
                            outc_d = '0;
                            cout_d = 1'b0;
                        end
`endif
                        default: begin
                            outc_d = '0;
                            cout_d = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE with Start skips the IDLE cycle entirely.
                if (Start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    carry_d = usesSub(Op);
                    a_d     = InA;
                    b_d     = InB;
                    op_d    = Op;
                    acc_d   = '0;
`ifdef SERIAL_ALU_CMP_EN
                    aMsb_d  = InA[XLEN-1];
                    bMsb_d  = InB[XLEN-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            acc_q   <= '0;
            outc_q  <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ALU_CMP_EN
            aMsb_q  <= 1'b0;
            bMsb_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            outc_q  <= outc_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ALU_CMP_EN
            aMsb_q  <= aMsb_d;
            bMsb_q  <= bMsb_d;
`endif
        end
    end

    assign Busy     = (state_q == RUN);
    assign Done     = (state_q == DONE);
    assign OutC     = outc_q;
    assign CarryOut = cout_q;
    assign Zero     = (outc_q == '0);

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu (XLEN=32, SLICE=4): expected results are queued at
// Start and compared at Done; honours SERIAL_ALU_CMP_EN for the SLT/SLTU expectations.
module tb_serial_alu;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] InA;
    logic [31:0] InB;
    logic        Busy;
    logic        Done;
    logic [31:0] OutC;
    logic        CarryOut;
    logic        Zero;

    typedef struct {
        logic [31:0] res;
        logic        cout;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    serial_alu #(.XLEN(32), .SLICE(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .InA(InA), .InB(InB),
        .Busy(Busy), .Done(Done), .OutC(OutC), .CarryOut(CarryOut), .Zero(Zero)
    );

    always #5 Clk = ~Clk;

    // Reference model written from the operation definitions, not from the slice datapath.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] w;
        e.res  = 32'd0;
        e.cout = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b};         e.res = w[31:0]; e.cout = w[32]; end
            3'd1: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; e.res = w[31:0]; e.cout = w[32]; end
            3'd2: e.res = a | b;
            3'd3: e.res = a ^ b;
            3'd4: e.res = a & b;
`ifdef SERIAL_ALU_CMP_EN
            3'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: e.res = (a < b) ? 32'd1 : 32'd0;
`endif
            default: ;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // Drives Start for one edge; after return we are sampling cycle 1 of the operation.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit push);
        Start = 1'b1;
        Op    = op;
        InA   = a;
        InB   = b;
        if (push) sbq.push_back(model(op, a, b));
        @(posedge Clk);
        #1;
        cyc   = 1;
        Start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        exp_t e;
        while (!Done && cyc < 40) tick();
        checkOutput({tag, "_done"}, {31'd0, Done}, 32'd1);
        checkOutput({tag, "_lat"}, cyc, 32'd9);
        if (sbq.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            checkOutput({tag, "_outc"}, OutC, e.res);
            checkOutput({tag, "_cout"}, {31'd0, CarryOut}, {31'd0, e.cout});
            checkOutput({tag, "_zero"}, {31'd0, Zero}, {31'd0, (e.res == 32'd0)});
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] ra, rb;
        int          doneSeen;
        logic        sltExp;

        Reset = 1'b1;
        Start = 1'b0;
        Op    = 3'd0;
        InA   = 32'd0;
        InB   = 32'd0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst_done", {31'd0, Done}, 32'd0);
        checkOutput("rst_outc", OutC, 32'd0);
        checkOutput("rst_cout", {31'd0, CarryOut}, 32'd0);
        checkOutput("rst_zero", {31'd0, Zero}, 32'd1);

        // First edge after reset release must accept.
        Reset = 1'b0;
        applyStimulus(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        checkOutput("add_busy1", {31'd0, Busy}, 32'd1);
        waitDone("add_wrap");
        tick();
        checkOutput("done_pulse", {31'd0, Done}, 32'd0);

        applyStimulus(3'd1, 32'h0000_0005, 32'h0000_0007, 1'b1);
        waitDone("sub");
        held = OutC;
        tick();
        tick();
        checkOutput("hold_outc", OutC, held);
        applyStimulus(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        waitDone("and");
        applyStimulus(3'd2, 32'h1234_0000, 32'h0000_5678, 1'b1);
        waitDone("or");
        applyStimulus(3'd3, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1);
        waitDone("xor");
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus(3'($urandom_range(0, 4)), ra, rb, 1'b1);
            waitDone("rand");
        end

        // Start during RUN cycle 3 with new operands must be ignored.
        applyStimulus(3'd0, 32'h1111_1111, 32'h2222_2222, 1'b1);
        tick();
        tick();
        Start = 1'b1;
        Op    = 3'd1;
        InA   = 32'hDEAD_BEEF;
        InB   = 32'h0BAD_F00D;
        tick();
        Start = 1'b0;
        checkOutput("ign_busy", {31'd0, Busy}, 32'd1);
        waitDone("ignore");

        // Start held on the Done cycle goes straight back to RUN.
        applyStimulus(3'd1, 32'h8000_0000, 32'h0000_0001, 1'b1);
        checkOutput("b2b_busy", {31'd0, Busy}, 32'd1);
        waitDone("b2b");

        // Asynchronous abort in RUN cycle 4.
        applyStimulus(3'd0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        tick();
        tick();
        tick();
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, Busy}, 32'd0);
        checkOutput("abort_outc", OutC, 32'd0);
        checkOutput("abort_zero", {31'd0, Zero}, 32'd1);
        checkOutput("abort_done", {31'd0, Done}, 32'd0);
        tick();
        Reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (Done) doneSeen++;
        end
        checkOutput("abort_nodone", doneSeen, 32'd0);
        checkOutput("abort_idle", {31'd0, Busy}, 32'd0);

        applyStimulus(3'd2, 32'h0000_00F0, 32'h0000_000F, 1'b1);
        waitDone("pre_rsv");
        applyStimulus(3'd7, 32'h1234_5678, 32'h1234_5678, 1'b1);
        waitDone("rsv");

        applyStimulus(3'd3, 32'h0000_0001, 32'h0000_0000, 1'b1);
        waitDone("pre_slt");
        applyStimulus(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
`ifdef SERIAL_ALU_CMP_EN
        sltExp = 1'b1;
`else
        sltExp = 1'b0;
`endif
        waitDone("slt");
        checkOutput("slt_fixed", OutC, {31'd0, sltExp});
        applyStimulus(3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        waitDone("sltu");
        checkOutput("sltu_fixed", OutC, 32'd0);
        applyStimulus(3'd6, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        waitDone("sltu_lt");
        applyStimulus(3'd5, 32'h0000_0003, 32'h8000_0000, 1'b1);
        waitDone("slt_pos");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
